aux_packet_scheduler: RTL

- Hardware traffic sequencer that drives the byte-stream error-detection datapath: the rx_en/rx_data interface consumed by detect_errors2.
- Emits bursts of fixed-length frames, each carrying a 16-bit aux sequence number and a cycling segment number.
- Supports inter-frame gaps, inter-burst pauses and deliberate sequence skips, so the loss/ok/ng counters can be exercised on-board without an external packet source.

---
 rtl/aux_packet_scheduler_pkg.sv | 32 +++
 rtl/aux_packet_scheduler_if.sv | 34 +++
 rtl/aux_packet_scheduler_wrap_counter.sv | 39 +++
 rtl/aux_packet_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/aux_packet_scheduler_pkg.sv
// Shared types and constants for the aux packet scheduler.
//   sched_state_t : FSM state encoding (also exported on the debug state port)
//   sched_cfg_t   : run configuration captured when a run starts
//   at_least_one  : maps a zero count to 1 for fields where 0 means "minimum"
package aux_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_IFG  = 3'd2,
    ST_BGAP = 3'd3,
    ST_DONE = 3'd4
  } sched_state_t;

  localparam logic [7:0] FILL_BYTE_DEF = 8'h12;

  // aux[7:0] sits this many bytes after aux[15:8] within a frame
  localparam int AUX_LO_OFFSET = 5;

  typedef struct packed {
    logic [15:0] seg_max;
    logic [15:0] ppb;
    logic [15:0] nb;
    logic [15:0] ifg;
    logic [15:0] gap;
  } sched_cfg_t;

  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/aux_packet_scheduler_if.sv
// Control, configuration and byte-stream bundle of the aux packet scheduler.
//   master : the scheduler (consumes control/config, drives stream + status)
//   slave  : the controlling side / stream consumer
interface aux_packet_scheduler_if;
  logic        start;
  logic        abort;
  logic        inject_skip;
  logic [15:0] segment_number_max;
  logic [15:0] packets_per_burst;
  logic [15:0] num_bursts;
  logic [15:0] ifg;
  logic [15:0] burst_gap;

  logic        tx_en;
  logic [7:0]  tx_data;
  logic [15:0] seg;
  logic [15:0] aux;
  logic [31:0] pkt_count;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  modport master (
    input  start, abort, inject_skip, segment_number_max, packets_per_burst,
           num_bursts, ifg, burst_gap,
    output tx_en, tx_data, seg, aux, pkt_count, busy, done, state
  );

  modport slave (
    output start, abort, inject_skip, segment_number_max, packets_per_burst,
           num_bursts, ifg, burst_gap,
    input  tx_en, tx_data, seg, aux, pkt_count, busy, done, state
  );
endinterface

// File: rtl/aux_packet_scheduler_wrap_counter.sv
// 16-bit counter that advances by 1 or 2 and wraps at a runtime modulus.
//   clk, rst : clock, async active-high reset (count -> 0)
//   en       : advance this cycle
//   modulus  : wrap point; values <= 1 pin the count at 0
//   step     : 1 or 2
//   count    : registered value
module wrap_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] modulus,
  input  logic [1:0]  step,
  output logic [15:0] count
);
  logic [16:0] sum;
  logic [15:0] count_d;

  // Only an exact hit on the modulus wraps, so a count left above a newly
  // smaller modulus keeps climbing instead of jumping to a remainder.
  always_comb begin
    sum     = {1'b0, count} + {15'd0, step};
    count_d = sum[15:0];
    if (modulus <= 16'd1) begin
      count_d = 16'd0;
    end else if (sum == {1'b0, modulus}) begin
      count_d = 16'd0;
    end else if (step == 2'd2 && sum == ({1'b0, modulus} + 17'd1)) begin
      count_d = 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'd0;
    end else if (en) begin
      count <= count_d;
    end
  end
endmodule

// File: rtl/aux_packet_scheduler.sv
// Frame/burst sequencer feeding the byte-stream error-detection datapath.
//   clk, rst     : clock, async active-high reset
//   bus (master) : start/abort/inject_skip + run config in;
//                  tx_en/tx_data stream, seg/aux/pkt_count, busy/done/state out
//
// state | meaning
// IDLE  | waiting for start, config not yet captured
// SEND  | one frame byte per cycle, PACKETSIZE cycles
// IFG   | idle gap between frames of a burst
// BGAP  | idle gap after the last frame of a burst
// DONE  | one-cycle done pulse, then IDLE
module aux_packet_scheduler
  import aux_sched_pkg::*;
#(
  parameter int         PACKETSIZE  = 33,
  parameter int         WHEREIS_AUX = 0,
  parameter int         MAXAUX      = 16,
  parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEF
) (
  input logic                    clk,
  input logic                    rst,
  aux_packet_scheduler_if.master bus
);
  localparam logic [15:0] LAST_IDX   = 16'(PACKETSIZE - 1);
  localparam logic [15:0] AUX_HI_IDX = 16'(WHEREIS_AUX);
  localparam logic [15:0] AUX_LO_IDX = 16'(WHEREIS_AUX + AUX_LO_OFFSET);
  localparam logic [15:0] AUX_MOD    = 16'(MAXAUX + 1);

  sched_state_t state_q, state_d;
  sched_cfg_t   cfg_q;
  logic [15:0]  byte_idx_q, byte_idx_d;
  logic [15:0]  wait_q;
  logic [15:0]  in_burst_q, burst_cnt_q;
  logic [31:0]  pkt_count_q;
  logic         skip_pend_q;
  logic [15:0]  aux_q, seg_q;

  logic         tx_en_q, tx_en_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic         last_byte, burst_full, run_complete, frame_end;
  logic [1:0]   aux_step;

  assign last_byte    = (state_q == ST_SEND) && (byte_idx_q == LAST_IDX);
  assign burst_full   = ({1'b0, in_burst_q} + 17'd1) >= {1'b0, cfg_q.ppb};
  assign run_complete = (cfg_q.nb != 16'd0) && (burst_cnt_q == cfg_q.nb);
  // An abort on the last byte truncates the frame, so nothing advances.
  assign frame_end    = last_byte && !bus.abort;
  // A pulse coinciding with the last byte is consumed by that same increment.
  assign aux_step     = (skip_pend_q || bus.inject_skip) ? 2'd2 : 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) state_d = ST_SEND;
        ST_SEND: if (last_byte) state_d = burst_full ? ST_BGAP : ST_IFG;
        ST_IFG:  if (wait_q == 16'd0) state_d = ST_SEND;
        ST_BGAP: if (wait_q == 16'd0) state_d = run_complete ? ST_DONE : ST_SEND;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered, so their next values are decoded from state_d.
  // aux_q is already settled whenever SEND is entered (the increment happens
  // on the way out of SEND and SEND is never re-entered directly).
  always_comb begin
    tx_en_d    = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    byte_idx_d = (state_q == ST_SEND && state_d == ST_SEND) ? byte_idx_q + 16'd1 : 16'd0;
    tx_data_d  = 8'h00;
    if (tx_en_d) begin
      if (byte_idx_d == AUX_HI_IDX) begin
        tx_data_d = aux_q[15:8];
      end else if (byte_idx_d == AUX_LO_IDX) begin
        tx_data_d = aux_q[7:0];
      end else begin
        tx_data_d = FILL_BYTE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      byte_idx_q  <= 16'd0;
      wait_q      <= 16'd0;
      in_burst_q  <= 16'd0;
      burst_cnt_q <= 16'd0;
      pkt_count_q <= 32'd0;
      skip_pend_q <= 1'b0;
      cfg_q       <= '0;
    end else begin
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      byte_idx_q <= byte_idx_d;

      if (state_q == ST_IDLE && bus.start) begin
        cfg_q.seg_max <= bus.segment_number_max;
        cfg_q.ppb     <= at_least_one(bus.packets_per_burst);
        cfg_q.nb      <= bus.num_bursts;
        cfg_q.ifg     <= at_least_one(bus.ifg);
        cfg_q.gap     <= at_least_one(bus.burst_gap);
        in_burst_q    <= 16'd0;
        burst_cnt_q   <= 16'd0;
      end

      if (frame_end) begin
        pkt_count_q <= pkt_count_q + 32'd1;
        if (burst_full) begin
          in_burst_q  <= 16'd0;
          burst_cnt_q <= burst_cnt_q + 16'd1;
        end else begin
          in_burst_q  <= in_burst_q + 16'd1;
        end
      end

      // Gap timer loads length-1 on entry and leaves when it reaches zero.
      if (state_d == ST_IFG && state_q != ST_IFG) begin
        wait_q <= cfg_q.ifg - 16'd1;
      end else if (state_d == ST_BGAP && state_q != ST_BGAP) begin
        wait_q <= cfg_q.gap - 16'd1;
      end else if ((state_q == ST_IFG || state_q == ST_BGAP) && wait_q != 16'd0) begin
        wait_q <= wait_q - 16'd1;
      end

      if (frame_end) begin
        skip_pend_q <= 1'b0;
      end else if (bus.inject_skip) begin
        skip_pend_q <= 1'b1;
      end
    end
  end

  wrap_counter u_aux_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (frame_end),
    .modulus (AUX_MOD),
    .step    (aux_step),
    .count   (aux_q)
  );

  wrap_counter u_seg_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (frame_end),
    .modulus (cfg_q.seg_max),
    .step    (2'd1),
    .count   (seg_q)
  );

  assign bus.tx_en     = tx_en_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.seg       = seg_q;
  assign bus.aux       = aux_q;
  assign bus.pkt_count = pkt_count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state     = state_q;
endmodule
